// File: rtl/fdiv_result_normalizer_if.sv
// Handshake bundle between the divider core, the result normalizer and the
// downstream consumer of packed single-precision results.
interface fdiv_result_normalizer_if #(
    parameter int EXP_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic signed [EXP_W-1:0] in_exp;
    logic [26:0]             in_quot;
    logic                    in_sticky;
    logic [1:0]              in_special;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_result;
    logic                    out_overflow;
    logic                    out_underflow;
    logic                    out_inexact;
    logic                    busy;

    modport slave (
        input  in_valid, in_sign, in_exp, in_quot, in_sticky, in_special, out_ready,
        output in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact, busy
    );

    modport master (
        output in_valid, in_sign, in_exp, in_quot, in_sticky, in_special, out_ready,
        input  in_ready, out_valid, out_result, out_overflow, out_underflow,
               out_inexact, busy
    );
endinterface

// File: rtl/fdiv_result_normalizer.sv
// Post-divide stage: renormalizes the raw quotient, rounds to nearest-even and
// packs an IEEE-754 single, with overflow/underflow/inexact flags.
module fdiv_result_normalizer #(
    parameter int EXP_W     = 10,
    parameter int MAX_SHIFT = 26
) (
    input logic                     clk,
    input logic                     rst,
    fdiv_result_normalizer_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_SHIFT + 1);
    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = EXP_W'(0);
    localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(255);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [26:0]             quot_q, quot_d;
    logic                    sticky_q, sticky_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [31:0]             result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    unf_q, unf_d;
    logic                    inx_q, inx_d;

    logic [22:0]             frac;
    logic                    guard;
    logic                    rnd_sticky;
    logic [23:0]             frac_sum;
    logic signed [EXP_W-1:0] exp_rnd;
    logic [33:0]             packed_res;

    function automatic logic [31:0] special_result(input logic s, input logic [1:0] cls);
        case (cls)
            2'b01:   return {s, 31'b0};
            2'b10:   return {s, 8'hFF, 23'b0};
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    function automatic logic round_inc(input logic g, input logic st, input logic lsb);
        return g & (st | lsb);
    endfunction

    // Returns {overflow, underflow, result}; exponent is range-checked at full width.
    function automatic logic [33:0] saturate_pack(input logic s,
                                                  input logic signed [EXP_W-1:0] e,
                                                  input logic [22:0] f);
        if (e >= EXP_MAX)       return {2'b10, s, 8'hFF, 23'b0};
        else if (e <= EXP_ZERO) return {2'b01, s, 31'b0};
        else                    return {2'b00, s, e[7:0], f};
    endfunction

    assign frac       = quot_q[24:2];
    assign guard      = quot_q[1];
    assign rnd_sticky = quot_q[0] | sticky_q;
    assign frac_sum   = {1'b0, frac} + {23'b0, round_inc(guard, rnd_sticky, frac[0])};
    assign exp_rnd    = exp_q + $signed({{(EXP_W-1){1'b0}}, frac_sum[23]});
    assign packed_res = saturate_pack(sign_q, exp_rnd, frac_sum[22:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

    always_ff @(posedge clk) begin
        sign_q   <= sign_d;
        exp_q    <= exp_d;
        quot_q   <= quot_d;
        sticky_q <= sticky_d;
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        quot_d   = quot_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.in_sign;
                    exp_d    = bus.in_exp;
                    quot_d   = bus.in_quot;
                    sticky_d = bus.in_sticky;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inx_d    = 1'b0;
                    if (bus.in_special != 2'b00) begin
                        result_d = special_result(bus.in_sign, bus.in_special);
                        state_d  = DONE;
                    end else begin
                        state_d  = NORM;
                    end
                end
            end
            NORM: begin
                if (quot_q == '0) begin
                    result_d = {sign_q, 31'b0};
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(MAX_SHIFT)) begin
                    result_d = {sign_q, 31'b0};
                    unf_d    = 1'b1;
                    state_d  = DONE;
                end else if (quot_q[26]) begin
                    quot_d   = {1'b0, quot_q[26:1]};
                    sticky_d = sticky_q | quot_q[0];
                    exp_d    = exp_q + EXP_ONE;
                    state_d  = ROUND;
                end else if (quot_q[25]) begin
                    state_d  = ROUND;
                end else begin
                    quot_d   = {quot_q[25:0], 1'b0};
                    exp_d    = exp_q - EXP_ONE;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ROUND: begin
                inx_d    = guard | rnd_sticky;
                ovf_d    = packed_res[33];
                unf_d    = packed_res[32];
                result_d = packed_res[31:0];
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready      = (state_q == IDLE);
        bus.busy          = (state_q != IDLE);
        bus.out_valid     = (state_q == DONE);
        bus.out_result    = result_q;
        bus.out_overflow  = ovf_q;
        bus.out_underflow = unf_q;
        bus.out_inexact   = inx_q;
    end
endmodule

// File: tb/tb_fdiv_result_normalizer.sv
// Directed bench for fdiv_result_normalizer: an arithmetic reference model drives
// a per-cycle output checker, with literal expectations pinning the model.
module tb_fdiv_result_normalizer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] m_res;
    logic        m_ovf, m_unf, m_inx;
    int          m_lat;
    bit          m_armed = 1'b0;

    fdiv_result_normalizer_if #(.EXP_W(10)) bus ();

    fdiv_result_normalizer #(.EXP_W(10), .MAX_SHIFT(26)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    // Reference: locate the leading one, align to a 24-bit significand, round RNE.
    function automatic void model(input logic s, input int e_in, input logic [26:0] q,
                                  input logic st_in, input logic [1:0] sp,
                                  output logic [31:0] res, output logic ovf,
                                  output logic unf, output logic inx, output int lat);
        int          p;
        int          e;
        logic [63:0] n;
        logic [24:0] sig;
        logic        g, st;
        ovf = 0; unf = 0; inx = 0;
        if (sp == 2'b01)      begin res = {s, 31'b0};         lat = 1; return; end
        else if (sp == 2'b10) begin res = {s, 8'hFF, 23'b0};  lat = 1; return; end
        else if (sp == 2'b11) begin res = 32'h7FC00000;       lat = 1; return; end
        if (q == 0) begin res = {s, 31'b0}; lat = 2; return; end
        p = 0;
        for (int i = 0; i < 27; i++) if (q[i]) p = i;
        lat = 3 + ((p < 25) ? (25 - p) : 0);
        e   = e_in + p - 25;
        n   = 64'(q) << (63 - p);
        sig = {1'b0, n[63:40]};
        g   = n[39];
        st  = (n[38:0] != 0) | st_in;
        inx = g | st;
        if (g && (st || sig[0])) sig = sig + 1;
        if (sig[24]) begin sig = 25'h0800000; e = e + 1; end
        if (e >= 255)     begin res = {s, 8'hFF, 23'b0}; ovf = 1; end
        else if (e <= 0)  begin res = {s, 31'b0};        unf = 1; end
        else              res = {s, e[7:0], sig[22:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_ready", 32'(bus.busy), 32'(!bus.in_ready));
            if (bus.out_valid) begin
                chk("valid_expected", 32'(m_armed), 32'd1);
                chk("ready_low_in_done", 32'(bus.in_ready), 32'd0);
                chk("result", bus.out_result, m_res);
                chk("flags_ovf_unf_inx",
                    {29'b0, bus.out_overflow, bus.out_underflow, bus.out_inexact},
                    {29'b0, m_ovf, m_unf, m_inx});
            end
        end
    end

    task automatic run(input logic s, input int e, input logic [26:0] q, input logic st,
                       input logic [1:0] sp, input int hold,
                       input bit use_lit, input logic [31:0] lit_res, input int lit_lat);
        int cyc;
        model(s, e, q, st, sp, m_res, m_ovf, m_unf, m_inx, m_lat);
        if (use_lit) begin
            chk("model_literal_result", m_res, lit_res);
            chk("model_literal_latency", 32'(m_lat), 32'(lit_lat));
        end
        @(negedge clk);
        chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid   = 1'b1;
        bus.in_sign    = s;
        bus.in_exp     = 10'(e);
        bus.in_quot    = q;
        bus.in_sticky  = st;
        bus.in_special = sp;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        m_armed      = 1'b1;
        cyc = 1;
        while (!bus.out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(m_lat));
        repeat (hold) @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        m_armed       = 1'b0;
        chk("valid_drop_after_take", 32'(bus.out_valid), 32'd0);
        chk("ready_back_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sign    = 1'b0;
        bus.in_exp     = '0;
        bus.in_quot    = '0;
        bus.in_sticky  = 1'b0;
        bus.in_special = 2'b00;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",
            {bus.out_result[27:0], bus.in_ready, bus.out_valid, bus.busy, bus.out_overflow},
            {28'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("reset_result", bus.out_result, 32'h0);
        rst = 1'b0;

        run(0, 127, 27'h3000000, 0, 2'b00, 0, 1, 32'h3FC00000, 3);
        run(0, 129, 27'h0800000, 0, 2'b00, 0, 1, 32'h3F800000, 5);
        run(0, 127, 27'h6000000, 0, 2'b00, 0, 1, 32'h40400000, 3);
        run(0, 127, 27'h2000003, 0, 2'b00, 0, 1, 32'h3F800001, 3);
        run(0, 127, 27'h2000002, 0, 2'b00, 0, 1, 32'h3F800000, 3);
        run(0, 127, 27'h3FFFFFE, 0, 2'b00, 0, 1, 32'h40000000, 3);
        run(0, 300, 27'h2000000, 0, 2'b00, 0, 1, 32'h7F800000, 3);
        run(1, -5,  27'h2000000, 0, 2'b00, 0, 1, 32'h80000000, 3);
        run(0, 127, 27'h0000000, 0, 2'b11, 0, 1, 32'h7FC00000, 1);
        run(1, 127, 27'h0000000, 0, 2'b10, 0, 1, 32'hFF800000, 1);
        run(1, 127, 27'h1234567, 0, 2'b01, 0, 1, 32'h80000000, 1);
        run(0, 127, 27'h0000000, 0, 2'b00, 0, 1, 32'h00000000, 2);
        run(0, 127, 27'h4000001, 0, 2'b00, 0, 1, 32'h40000000, 3);
        run(0, 127, 27'h2000000, 1, 2'b00, 0, 1, 32'h3F800000, 3);
        run(0, 1,   27'h1000000, 0, 2'b00, 0, 1, 32'h00000000, 4);
        run(0, 254, 27'h3FFFFFE, 0, 2'b00, 0, 1, 32'h7F800000, 3);
        run(1, 140, 27'h0000001, 0, 2'b00, 0, 0, 32'h0, 0);
        run(0, 100, 27'h5555555, 1, 2'b00, 10, 0, 32'h0, 0);

        // Abort a long normalization partway through with a synchronous reset.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 10'd140;
        bus.in_quot  = 27'h0000100;
        bus.in_sticky  = 1'b0;
        bus.in_special = 2'b00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_mid_norm", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_mid_norm_state",
            {29'b0, bus.in_ready, bus.out_valid, bus.busy}, {29'b0, 1'b1, 1'b0, 1'b0});
        chk("reset_mid_norm_result", bus.out_result, 32'h0);
        run(0, 127, 27'h3000000, 0, 2'b00, 2, 1, 32'h3FC00000, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fdiv_result_normalizer.md
Name: fdiv_result_normalizer

Overview:
- Post-division stage of the FP divide path; the counterpart of the pre-division operand normalizer.
- Accepts a raw quotient mantissa, a biased result exponent and special-case flags from the divider core.
- Renormalizes the mantissa, rounds it to nearest-even and rebuilds the IEEE-754 single-precision result.
- Multi-cycle FSM with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 10: width of the signed internal exponent (in_exp and exponent register).
- MAX_SHIFT, 26: maximum number of left-normalization steps; reaching it flushes the result to zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sign  in  1  result sign (N sign XOR D sign).
- in_exp  in  EXP_W  signed, biased result exponent (eN - eD + 127).
- in_quot  in  27  quotient, unsigned fixed point, value = in_quot / 2^25, range [0,4).
- in_sticky  in  1  OR of remainder bits lost by the divider.
- in_special  in  2  operand class: 00 normal, 01 zero, 10 inf, 11 NaN.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  packed IEEE-754 single.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result flushed to zero (no subnormal support).
- out_inexact  out  1  guard or sticky bit was nonzero.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0, busy=0, shift counter 0. rst overrides all other inputs.
- Reset during any state returns to IDLE on the next edge; any in-flight result is discarded and out_valid drops.
- States: IDLE, NORM, ROUND, DONE.

IDLE:
- Accept on an edge with in_valid && in_ready. Latch sign, exp, quot, sticky; clear the shift counter.
- If in_special != 00, go directly to DONE with the special result:
  - zero: {sign, 31'b0}
  - inf: {sign, 8'hFF, 23'b0}
  - NaN: 32'h7FC00000
  - All flags 0.
- Otherwise go to NORM.

NORM (one decision per cycle):
- quot == 0: zero result, underflow=0, go to DONE.
- quot[26] == 1: shift right 1, OR the bit shifted out into sticky, exp += 1, go to ROUND.
- quot[25] == 1: go to ROUND.
- Otherwise: shift left 1, exp -= 1, counter += 1, stay in NORM.
- Counter reaching MAX_SHIFT: signed-zero result, underflow=1, go to DONE.

ROUND:
- Mantissa fields: fraction = quot[24:2], guard = quot[1], sticky = quot[0] | sticky.
- Round to nearest-even: increment when guard && (sticky || fraction[0]).
- inexact = guard | sticky.
- Fraction carry-out: fraction becomes 0 and exp += 1.
- After rounding:
  - exp >= 255: {sign, 8'hFF, 0}, overflow=1.
  - exp <= 0: {sign, 31'b0}, underflow=1.
  - Otherwise: {sign, exp[7:0], fraction}.
- Go to DONE.

DONE:
- out_valid=1; out_result and flags held stable while out_ready=0.
- On an edge with out_ready=1: out_valid drops and the FSM returns to IDLE.
- A new input is not accepted in that same cycle (in_ready is 0 in DONE).

Latency, accept edge to out_valid high:
- Special input: 1 cycle.
- Zero quotient: 2 cycles.
- Normal input: 3 cycles + 1 per left shift.

Widths and flags:
- All exponent arithmetic is EXP_W-bit signed; exp is never truncated before the range check.
- Flags are valid only while out_valid=1 and are cleared on accept.

Test Plan:
- quot=27'h3000000, exp=127, sign=0 -> out_result=32'h3FC00000 (1.5) three cycles after accept, all flags 0.
- quot=27'h0800000, exp=129 -> two left shifts, out_result=32'h3F800000, out_valid five cycles after accept; quot=27'h6000000, exp=127 -> 32'h40400000 in three cycles.
- Rounding cases:
  - quot=27'h2000003 -> 32'h3F800001, inexact=1.
  - quot=27'h2000002 (tie, even) -> 32'h3F800000, inexact=1.
  - quot=27'h3FFFFFE -> carry -> 32'h40000000.
- Range limits:
  - exp=300 -> 32'h7F800000, overflow=1.
  - exp=-5, sign=1 -> 32'h80000000, underflow=1.
  - in_special=11 -> 32'h7FC00000 one cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles -> out_result and flags stable, in_ready=0 throughout; release out_ready -> IDLE next cycle, in_ready=1.
- Reset: assert rst in NORM mid-shift -> next edge IDLE, out_valid=0, out_result=0; a fresh input afterwards produces a correct result.
